usb_tx_arbiter: RTL

Shares the single USB-serial transmit pipe (device→host, the usb_uart_i40 uart_in_* interface) between two byte-stream requesters, e.g. the loopback echo path and the Boneless CPU console.
- Arbitration is burst-granular and round-robin.
- A granted requester keeps the pipe until it marks its last byte or hits a burst cap, so host-side byte streams never interleave mid-message.
- Sits between the requesters and usb_uart_i40, in the 48 MHz domain.

---
 rtl/usb_tx_arbiter_pkg.sv | 16 +
 rtl/usb_tx_outreg.sv | 39 +++
 rtl/usb_tx_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/usb_tx_arbiter_pkg.sv
// usb_tx_arbiter_pkg: state encoding, requester indices and default tag bytes shared by the USB TX arbiter
package usb_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TAG   = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    localparam int REQ0 = 0;
    localparam int REQ1 = 1;

    localparam logic [7:0] DEF_TAG0 = 8'hA0;
    localparam logic [7:0] DEF_TAG1 = 8'hA1;

endpackage

// File: rtl/usb_tx_outreg.sv
// usb_tx_outreg: single-entry valid/ready byte register feeding the USB-serial transmit pipe
module usb_tx_outreg
    import usb_tx_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       free
);

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    assign free      = !valid_q || out_ready;
    assign out_data  = data_q;
    assign out_valid = valid_q;

    // A load always wins; otherwise the held byte drains once the pipe accepts it
    always_comb begin
        data_d  = load ? load_data : data_q;
        valid_d = load || (valid_q && !out_ready);
    end

    // Register state; reset drops any byte in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: burst-granular round-robin arbiter sharing the USB-serial TX pipe between two byte streams (optional per-burst header bytes under USB_ARB_TAG_EN)
module usb_tx_arbiter
    import usb_tx_arbiter_pkg::*;
#(
    parameter int         MAX_BURST = 64,
    parameter logic [7:0] TAG0      = DEF_TAG0,
    parameter logic [7:0] TAG1      = DEF_TAG1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] grant
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          rr_q, rr_d;
    logic          free, load, hs, sel_last, pick;
    logic [7:0]    sel_data, load_data, tag_byte;

    assign grant      = grant_q;
    assign req0_ready = (state_q == BURST) && grant_q[REQ0] && free;
    assign req1_ready = (state_q == BURST) && grant_q[REQ1] && free;
    assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign sel_data   = grant_q[REQ1] ? req1_data : req0_data;
    assign sel_last   = grant_q[REQ1] ? req1_last : req0_last;
    assign tag_byte   = grant_q[REQ1] ? TAG1 : TAG0;
    assign cnt_inc    = cnt_q + CW'(1);
    // rr_q holds the index last granted, so a tie goes to the other requester
    assign pick       = (req0_valid && req1_valid) ? !rr_q : req1_valid;

    // Arbitration FSM: pick an owner, optionally emit its tag, then pass bytes until last or cap
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        load      = 1'b0;
        load_data = sel_data;
        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = pick ? 2'b10 : 2'b01;
                    rr_d    = pick;
`ifdef USB_ARB_TAG_EN
                    state_d = TAG;
`else
                    state_d = BURST;
`endif
                end
            end
            TAG: begin
                if (free) begin
                    load      = 1'b1;
                    load_data = tag_byte;
                    state_d   = BURST;
                end
            end
            BURST: begin
                if (hs) begin
                    load  = 1'b1;
                    cnt_d = cnt_inc;
                    if (sel_last || cnt_inc == CW'(MAX_BURST)) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, owner, burst count and round-robin pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            cnt_q   <= '0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    usb_tx_outreg u_outreg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .free      (free)
    );

endmodule
